nes_pad_reader: RTL and testbench



---
 rtl/nes_pad_reader.sv | 195 +++++++++++++++++++
 tb/tb_nes_pad_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/nes_pad_reader.sv
// Two-pad NES controller poller: a shared latch/pulse pair, one data line per pad, registered outputs.
// Optional macro NES_PAD_FRAME_FILTER_EN: outputs load only when two consecutive captures agree.
module nes_pad_reader #(
  parameter int POLL_CYCLES  = 833333,
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_CYCLES  = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pad_data,
  output logic        pad_latch,
  output logic        pad_pulse,
  output logic [0:11] controller_inputs,
  output logic [0:3]  aux_buttons,
  output logic        frame_valid
);

  localparam int PW  = $clog2(POLL_CYCLES + 1);
  localparam int PHW = $clog2(((LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES) + 1);
  localparam logic [PW-1:0]  POLL_LAST  = PW'(POLL_CYCLES - 1);
  localparam logic [PHW-1:0] LATCH_LAST = PHW'(LATCH_CYCLES - 1);
  localparam logic [PHW-1:0] HALF_LAST  = PHW'(HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOW,
    S_HIGH,
    S_UPDATE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [PW-1:0]    r_poll;
  logic [PHW-1:0]   r_phase;
  logic [PHW-1:0]   w_phase_next;
  logic [2:0]       r_bit;
  logic [2:0]       w_bit_next;
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0][7:0]  r_cap;
  logic [1:0][7:0]  w_cap_next;
  logic             w_load;
  logic             w_take;
  logic             r_latch;
  logic             r_pulse;
  logic             r_fv;
  logic [0:11]      r_ci;
  logic [0:3]       r_aux;
  logic [0:11]      w_new_ci;
  logic [0:3]       w_new_aux;

  // Double-flop each asynchronous pad line; released (high) out of reset.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_sync1[gi] <= 1'b1;
          r_sync2[gi] <= 1'b1;
        end else begin
          r_sync1[gi] <= pad_data[gi];
          r_sync2[gi] <= r_sync1[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_poll <= '0;
    end else if (r_poll == POLL_LAST) begin
      r_poll <= '0;
    end else begin
      r_poll <= r_poll + PW'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase + PHW'(1);
    w_bit_next   = r_bit;
    w_load       = 1'b0;
    w_cap_next   = r_cap;
    case (r_state)
      S_IDLE: begin
        w_phase_next = '0;
        if (r_poll == '0) begin
          w_state_next = S_LATCH;
        end
      end
      S_LATCH: begin
        if (r_phase == LATCH_LAST) begin
          w_phase_next = '0;
          w_state_next = S_LOW;
        end
      end
      S_LOW: begin
        if (r_phase == HALF_LAST) begin
          // Pads drive low for pressed; store as active-high flags.
          for (int p = 0; p < 2; p++) begin
            w_cap_next[p][r_bit] = ~r_sync2[p];
          end
          w_phase_next = '0;
          if (r_bit == 3'd7) begin
            w_load       = 1'b1;
            w_state_next = S_UPDATE;
          end else begin
            w_state_next = S_HIGH;
          end
        end
      end
      S_HIGH: begin
        if (r_phase == HALF_LAST) begin
          w_phase_next = '0;
          w_bit_next   = r_bit + 3'd1;
          w_state_next = S_LOW;
        end
      end
      S_UPDATE: begin
        w_phase_next = '0;
        w_bit_next   = 3'd0;
        w_state_next = S_IDLE;
      end
      default: begin
        w_phase_next = '0;
        w_bit_next   = 3'd0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Serial order per pad: A, B, Select, Start, Up, Down, Left, Right.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_map
      assign w_new_ci[gi*6 + 0] = w_cap_next[gi][6];
      assign w_new_ci[gi*6 + 1] = w_cap_next[gi][7];
      assign w_new_ci[gi*6 + 2] = w_cap_next[gi][4];
      assign w_new_ci[gi*6 + 3] = w_cap_next[gi][5];
      assign w_new_ci[gi*6 + 4] = w_cap_next[gi][0];
      assign w_new_ci[gi*6 + 5] = w_cap_next[gi][1];
      assign w_new_aux[gi*2 + 0] = w_cap_next[gi][2];
      assign w_new_aux[gi*2 + 1] = w_cap_next[gi][3];
    end
  endgenerate

`ifdef NES_PAD_FRAME_FILTER_EN
  logic [1:0][7:0] r_prev;

  assign w_take = w_load && (w_cap_next == r_prev);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev <= '0;
    end else if (w_load) begin
      r_prev <= w_cap_next;
    end
  end
`else
  assign w_take = w_load;
`endif

  // Outputs and strobe change on the edge that enters UPDATE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_bit   <= 3'd0;
      r_cap   <= '0;
      r_latch <= 1'b0;
      r_pulse <= 1'b0;
      r_fv    <= 1'b0;
      r_ci    <= '0;
      r_aux   <= '0;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
      r_bit   <= w_bit_next;
      r_cap   <= w_cap_next;
      r_latch <= (w_state_next == S_LATCH);
      r_pulse <= (w_state_next == S_HIGH);
      r_fv    <= w_load;
      if (w_take) begin
        r_ci  <= w_new_ci;
        r_aux <= w_new_aux;
      end
    end
  end

  assign pad_latch         = r_latch;
  assign pad_pulse         = r_pulse;
  assign frame_valid       = r_fv;
  assign controller_inputs = r_ci;
  assign aux_buttons       = r_aux;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Scoreboard bench for nes_pad_reader: pad shift-register model, directed frames, a short-poll timing instance.
module tb_nes_pad_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rst2;
  logic [1:0]  pad_data;
  logic        pad_latch, pad_pulse, frame_valid;
  logic [0:11] controller_inputs;
  logic [0:3]  aux_buttons;
  logic        latch2, pulse2, fv2;
  logic [0:11] ci2;
  logic [0:3]  aux2;

  nes_pad_reader #(.POLL_CYCLES(100), .LATCH_CYCLES(4), .HALF_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .pad_data(pad_data), .pad_latch(pad_latch), .pad_pulse(pad_pulse),
    .controller_inputs(controller_inputs), .aux_buttons(aux_buttons), .frame_valid(frame_valid)
  );

  nes_pad_reader #(.POLL_CYCLES(20), .LATCH_CYCLES(4), .HALF_CYCLES(2)) dut_short (
    .clk(clk), .rst(rst2), .pad_data(2'b11), .pad_latch(latch2), .pad_pulse(pulse2),
    .controller_inputs(ci2), .aux_buttons(aux2), .frame_valid(fv2)
  );

  // Pad model: buttons in serial order {Right,Left,Down,Up,Start,Select,B,A}, active high.
  logic [7:0] btn1, btn2, sr1, sr2;
  initial begin
    sr1 = 8'hFF;
    sr2 = 8'hFF;
  end
  always @(posedge pad_latch or posedge pad_pulse) begin
    if (pad_latch) begin
      sr1 <= ~btn1;
      sr2 <= ~btn2;
    end else begin
      sr1 <= {1'b1, sr1[7:1]};
      sr2 <= {1'b1, sr2[7:1]};
    end
  end
  assign pad_data = {sr2[0], sr1[0]};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [0:11] ci;
    logic [0:3]  aux;
  } exp_t;
  exp_t q[$];

  logic [7:0]  vb1 [6];
  logic [7:0]  vb2 [6];
  logic [0:11] vci [6];
  logic [0:3]  vaux[6];

  logic [0:11] m_ci;
  logic [0:3]  m_aux;
  logic [15:0] m_prev;

  task automatic push_v(input int k);
    btn1 = vb1[k];
    btn2 = vb2[k];
`ifdef NES_PAD_FRAME_FILTER_EN
    if ({vb2[k], vb1[k]} == m_prev) begin
      m_ci  = vci[k];
      m_aux = vaux[k];
    end
    m_prev = {vb2[k], vb1[k]};
`else
    m_ci  = vci[k];
    m_aux = vaux[k];
`endif
    q.push_back({m_ci, m_aux});
    $display("push frame vector %0d p1=%b p2=%b exp_ci=%b exp_aux=%b", k, vb1[k], vb2[k], m_ci, m_aux);
  endtask

  task automatic wait_fv();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_valid) return;
    end
    chk("fv_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_latch();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pad_latch) return;
    end
    chk("latch_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: pops on each strobe; outputs must not move without one.
  exp_t        mon_e;
  logic [0:11] prev_ci = '0;
  logic [0:3]  prev_aux = '0;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (frame_valid) begin
        if (q.size() == 0) begin
          chk("sb_unexpected_frame", 32'd1, 32'd0);
        end else begin
          mon_e = q.pop_front();
          $display("frame ci=%b aux=%b exp_ci=%b exp_aux=%b", controller_inputs, aux_buttons, mon_e.ci, mon_e.aux);
          chk("sb_ci", 32'(controller_inputs), 32'(mon_e.ci));
          chk("sb_aux", 32'(aux_buttons), 32'(mon_e.aux));
        end
      end else begin
        chk("hold_outputs", {16'd0, controller_inputs, aux_buttons}, {16'd0, prev_ci, prev_aux});
      end
    end
    prev_ci  = controller_inputs;
    prev_aux = aux_buttons;
  end

  // Short-poll instance: frames start at 1, 41, 81, 121; strobes at 35, 75, 115.
  initial begin
    int rises;
    logic pl;
    rises = 0;
    pl = 1'b0;
    wait (rst2 === 1'b1);
    for (int c2 = 1; c2 <= 130; c2++) begin
      @(negedge clk);
      if (latch2 && !pl) begin
        rises++;
        $display("short_poll latch rise at cycle %0d", c2);
        chk("short_latch_rise_cycle", 32'((c2 - 1) % 40), 32'd0);
      end
      if (fv2) chk("short_fv_cycle", 32'(c2 % 40), 32'd35);
      pl = latch2;
    end
    chk("short_rise_count", 32'(rises), 32'd4);
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [0:11] hold_ci;
  logic [0:3]  hold_aux;

  initial begin
    int o;
    vb1[0] = 8'b0000_0000; vb2[0] = 8'b0000_0000; vci[0] = 12'b0000_0000_0000; vaux[0] = 4'b0000;
    vb1[1] = 8'b0100_0001; vb2[1] = 8'b1000_1000; vci[1] = 12'b1000_1001_0000; vaux[1] = 4'b0001;
    vb1[2] = 8'b0011_0110; vb2[2] = 8'b0100_0011; vci[2] = 12'b0011_0110_0011; vaux[2] = 4'b1000;
    vb1[3] = 8'b1111_1111; vb2[3] = 8'b1111_1111; vci[3] = 12'b1111_1111_1111; vaux[3] = 4'b1111;
    vb1[4] = 8'b1000_1000; vb2[4] = 8'b0011_0100; vci[4] = 12'b0100_0000_1100; vaux[4] = 4'b0110;
    vb1[5] = 8'b0000_0010; vb2[5] = 8'b0000_0000; vci[5] = 12'b0000_0100_0000; vaux[5] = 4'b0000;
    m_ci = '0; m_aux = '0; m_prev = '0;
    rst = 1'b0; rst2 = 1'b0;
    btn1 = '0; btn2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_latch", 32'(pad_latch), 32'd0);
    chk("reset_ci", 32'(controller_inputs), 32'd0);
    chk("reset_fv", 32'(frame_valid), 32'd0);
    push_v(0);
    rst = 1'b1; rst2 = 1'b1;

    // First frame waveform, then second latch at the counter wrap.
    for (int c = 1; c <= 102; c++) begin
      @(negedge clk);
      o = (c <= 100) ? c : c - 100;
      chk("wave_latch", 32'(pad_latch), 32'(o >= 1 && o <= 4));
      chk("wave_pulse", 32'(pad_pulse), 32'(o >= 5 && o <= 34 && (((o - 5) / 2) % 2 == 1)));
      chk("wave_fv", 32'(frame_valid), 32'(o == 35));
      if (c == 50) push_v(1);
    end
    wait_fv();

    // Pads change mid-frame: outputs hold until the strobe.
    hold_ci = m_ci; hold_aux = m_aux;
    push_v(2);
    wait_latch();
    repeat (10) @(negedge clk);
    btn1 = vb1[3]; btn2 = vb2[3];
    for (int i = 0; i < 3; i++) begin
      repeat (6) @(negedge clk);
      chk("midframe_hold", {16'd0, controller_inputs, aux_buttons}, {16'd0, hold_ci, hold_aux});
    end
    wait_fv();
    push_v(3);
    wait_fv();
    push_v(4);
    wait_fv();

    // Reset at cycle 15 of a frame.
    push_v(4);
    wait_latch();
    repeat (14) @(negedge clk);
    chk("pre_reset_pulse", 32'(pad_pulse), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rst_latch", 32'(pad_latch), 32'd0);
    chk("rst_pulse", 32'(pad_pulse), 32'd0);
    chk("rst_fv", 32'(frame_valid), 32'd0);
    chk("rst_ci", 32'(controller_inputs), 32'd0);
    chk("rst_aux", 32'(aux_buttons), 32'd0);
    void'(q.pop_back());
    m_ci = '0; m_aux = '0; m_prev = '0;
    repeat (3) @(negedge clk);
    push_v(5);
    rst = 1'b1;
    @(negedge clk);
    chk("restart_latch", 32'(pad_latch), 32'd1);
    wait_fv();
    push_v(0);
    wait_fv();
    push_v(5);
    wait_fv();
    push_v(5);
    wait_fv();
    chk("p1_b_after_two_frames", 32'(controller_inputs[5]), 32'd1);
    push_v(0);
    wait_fv();
    @(negedge clk);
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
